// File: rtl/exu_issue_pkg.sv
// Shared definitions for the operand-issue stage: opcodes, ALU function keys, class tags and
// the decoded-beat record carried through the output register and skid entry.
package exu_issue_pkg;

    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;

    // Key layout is {funct3[2:0], funct7[6:0]}.
    localparam logic [9:0] KeyAdd  = 10'h000;
    localparam logic [9:0] KeySub  = 10'h020;
    localparam logic [9:0] KeySlt  = 10'h100;
    localparam logic [9:0] KeySltu = 10'h180;
    localparam logic [9:0] KeySra  = 10'h2A0;

    typedef enum logic [2:0] {
        ClsAlu     = 3'd0,
        ClsLoad    = 3'd1,
        ClsStore   = 3'd2,
        ClsBranch  = 3'd3,
        ClsJump    = 3'd4,
        ClsIllegal = 3'd7
    } cls_e;

    typedef struct packed {
        logic [31:0] asrc1;
        logic [31:0] asrc2;
        logic [9:0]  func;
        logic [4:0]  rd;
        cls_e        cls;
        logic [31:0] pc;
    } issue_t;

    function automatic logic [9:0] func_key(input logic [2:0] f3, input logic [6:0] f7);
        return {f3, f7};
    endfunction

endpackage

// File: rtl/exu_issue_decode.sv
// Combinational decode of one RV32I instruction into ALU operands, function key, rd and class.
module issue_decode
    import exu_issue_pkg::*;
(
    input  logic [31:0] inst,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output issue_t      dec
);

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [31:0] imm_i;
    logic [31:0] imm_u;
    logic [31:0] shamt;
    logic        is_shift;

    assign opcode   = inst[6:0];
    assign rd       = inst[11:7];
    assign f3       = inst[14:12];
    assign f7       = inst[31:25];
    assign imm_i    = {{20{inst[31]}}, inst[31:20]};
    assign imm_u    = {inst[31:12], 12'h000};
    assign shamt    = {27'h0, inst[24:20]};
    assign is_shift = (f3 == 3'd1) || (f3 == 3'd5);

    always_comb begin
        dec = '{asrc1: '0, asrc2: '0, func: KeyAdd, rd: '0, cls: ClsIllegal, pc: pc};
        case (opcode)
            OpcOp: begin
                dec.asrc1 = rs1_data;
                dec.asrc2 = rs2_data;
                dec.func  = func_key(f3, f7);
                dec.rd    = rd;
                dec.cls   = ClsAlu;
            end
            OpcOpImm: begin
                // Shifts pass only shamt; funct7 survives in the key for SRAI/SRLI.
                dec.asrc1 = rs1_data;
                dec.asrc2 = is_shift ? shamt : imm_i;
                dec.func  = func_key(f3, (f3 == 3'd5) ? f7 : 7'h00);
                dec.rd    = rd;
                dec.cls   = ClsAlu;
            end
            OpcLui: begin
                dec.asrc2 = imm_u;
                dec.rd    = rd;
                dec.cls   = ClsAlu;
            end
            OpcAuipc: begin
                dec.asrc1 = pc;
                dec.asrc2 = imm_u;
                dec.rd    = rd;
                dec.cls   = ClsAlu;
            end
            OpcJal, OpcJalr: begin
                dec.asrc1 = pc;
                dec.asrc2 = 32'd4;
                dec.rd    = rd;
                dec.cls   = ClsJump;
            end
            OpcLoad: begin
                dec.asrc1 = rs1_data;
                dec.asrc2 = rs2_data;
                dec.rd    = rd;
                dec.cls   = ClsLoad;
            end
            OpcStore: begin
                dec.asrc1 = rs1_data;
                dec.asrc2 = rs2_data;
                dec.cls   = ClsStore;
            end
            OpcBranch: begin
                // funct3 010/011 are not branches and stay illegal.
                if (f3[2:1] != 2'b01) begin
                    dec.asrc1 = rs1_data;
                    dec.asrc2 = rs2_data;
                    dec.cls   = ClsBranch;
                    case (f3[2:1])
                        2'b00:   dec.func = KeySub;
                        2'b10:   dec.func = KeySlt;
                        default: dec.func = KeySltu;
                    endcase
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/exu_issue.sv
// Operand-issue stage between IDU and EXU: decode, valid/ready handshake, flush.
// ISSUE_SKID_EN adds a skid entry so in_ready is registered and independent of out_ready.
module exu_issue
    import exu_issue_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter logic [31:0] RST_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] asrc1,
    output logic [XLEN-1:0] asrc2,
    output logic [9:0]      funcEU,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_pc,
    output logic [2:0]      out_cls
);

    localparam issue_t ResetBeat = '{asrc1: '0, asrc2: '0, func: '0, rd: '0, cls: ClsAlu,
                                     pc: RST_PC};

    issue_t dec;
    issue_t out_q, out_d;
    logic   out_valid_q, out_valid_d;
    logic   out_load;
    logic   in_fire;

    assign rs1_addr = in_inst[19:15];
    assign rs2_addr = in_inst[24:20];

    issue_decode u_decode (
        .inst     (in_inst),
        .pc       (in_pc),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .dec      (dec)
    );

    assign out_load = !out_valid_q || out_ready;
    assign in_fire  = in_valid && in_ready;

`ifdef ISSUE_SKID_EN
    issue_t skid_q, skid_d;
    logic   skid_valid_q, skid_valid_d;

    assign in_ready = !rst && !flush && !skid_valid_q;

    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (out_load) begin
            // A parked beat is older than anything upstream, so it always goes first.
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                out_d       = dec;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            skid_q       <= ResetBeat;
            skid_valid_q <= 1'b0;
        end else begin
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end
`else
    assign in_ready = !rst && !flush && out_load;

    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (out_load) begin
            out_valid_d = in_fire;
            if (in_fire) begin
                out_d = dec;
            end
        end
        if (flush) begin
            out_valid_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q       <= ResetBeat;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign asrc1     = out_q.asrc1;
    assign asrc2     = out_q.asrc2;
    assign funcEU    = out_q.func;
    assign out_rd    = out_q.rd;
    assign out_pc    = out_q.pc;
    assign out_cls   = out_q.cls;

endmodule

// File: tb/tb_exu_issue.sv
// Scoreboard bench for exu_issue: directed RV32I beats with literal expectations, then
// randomized traffic with stalls, flushes and resets checked against a reference decoder.
module tb_exu_issue;

    localparam logic [31:0] RstPc = 32'h8000_0000;

    typedef struct packed {
        logic [31:0] asrc1;
        logic [31:0] asrc2;
        logic [9:0]  func;
        logic [4:0]  rd;
        logic [2:0]  cls;
        logic [31:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_inst = '0;
    logic [31:0] in_pc = '0;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] asrc1, asrc2, out_pc;
    logic [9:0]  funcEU;
    logic [4:0]  out_rd;
    logic [2:0]  out_cls;

    int   checks = 0;
    int   failures = 0;
    exp_t sb_q[$];
    bit   use_dir = 1'b0;
    exp_t dir_exp;

    always #5 clk = ~clk;

    exu_issue #(
        .XLEN   (32),
        .RST_PC (RstPc)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_inst   (in_inst),
        .in_pc     (in_pc),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .asrc1     (asrc1),
        .asrc2     (asrc2),
        .funcEU    (funcEU),
        .out_rd    (out_rd),
        .out_pc    (out_pc),
        .out_cls   (out_cls)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decoder built directly from the instruction-class table.
    function automatic exp_t ref_issue(input logic [31:0] inst, input logic [31:0] pc,
                                       input logic [31:0] r1, input logic [31:0] r2);
        exp_t        e;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm_i;
        logic [31:0] imm_u;
        f3    = inst[14:12];
        f7    = inst[31:25];
        imm_i = $unsigned($signed(inst) >>> 20);
        imm_u = inst & 32'hFFFF_F000;
        e     = '{asrc1: 0, asrc2: 0, func: 0, rd: 0, cls: 3'd7, pc: pc};
        case (inst[6:0])
            7'h33: e = '{asrc1: r1, asrc2: r2, func: {f3, f7}, rd: inst[11:7], cls: 0, pc: pc};
            7'h13: begin
                e = '{asrc1: r1, asrc2: imm_i, func: {f3, 7'h00}, rd: inst[11:7], cls: 0, pc: pc};
                if (f3 == 3'd1 || f3 == 3'd5) e.asrc2 = {27'h0, inst[24:20]};
                if (f3 == 3'd5) e.func = {f3, f7};
            end
            7'h37: e = '{asrc1: 0, asrc2: imm_u, func: 0, rd: inst[11:7], cls: 0, pc: pc};
            7'h17: e = '{asrc1: pc, asrc2: imm_u, func: 0, rd: inst[11:7], cls: 0, pc: pc};
            7'h6F, 7'h67: e = '{asrc1: pc, asrc2: 4, func: 0, rd: inst[11:7], cls: 4, pc: pc};
            7'h03: e = '{asrc1: r1, asrc2: r2, func: 0, rd: inst[11:7], cls: 1, pc: pc};
            7'h23: e = '{asrc1: r1, asrc2: r2, func: 0, rd: 0, cls: 2, pc: pc};
            7'h63: begin
                if (f3 == 3'd0 || f3 == 3'd1)
                    e = '{asrc1: r1, asrc2: r2, func: 10'h020, rd: 0, cls: 3, pc: pc};
                else if (f3 == 3'd4 || f3 == 3'd5)
                    e = '{asrc1: r1, asrc2: r2, func: 10'h100, rd: 0, cls: 3, pc: pc};
                else if (f3 == 3'd6 || f3 == 3'd7)
                    e = '{asrc1: r1, asrc2: r2, func: 10'h180, rd: 0, cls: 3, pc: pc};
            end
            default: ;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        logic [6:0]  opcs[9];
        opcs = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h23, 7'h63};
        w = $urandom;
        if ($urandom_range(0, 9) != 0) w[6:0] = opcs[$urandom_range(0, 8)];
        if (w[6:0] == 7'h63 && w[14:13] == 2'b01) w[14] = 1'b1;
        return w;
    endfunction

    task automatic cycle(input bit v, input bit rdy, input bit fl, input bit r);
        @(negedge clk);
        in_valid  = v;
        out_ready = rdy;
        flush     = fl;
        rst       = r;
        use_dir   = 1'b0;
        in_inst   = rand_inst();
        in_pc     = $urandom & 32'hFFFF_FFFC;
        rs1_data  = $urandom;
        rs2_data  = $urandom;
    endtask

    task automatic dir_beat(input logic [31:0] inst, input logic [31:0] pc, input exp_t e);
        @(negedge clk);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        flush     = 1'b0;
        rst       = 1'b0;
        use_dir   = 1'b1;
        in_inst   = inst;
        in_pc     = pc;
        rs1_data  = 32'd5;
        rs2_data  = 32'd7;
        dir_exp   = e;
    endtask

    // Monitor: samples 1ns before each rising edge.
    initial begin : monitor
        bit   prev_rst;
        bit   exp_ready;
        exp_t f;
        prev_rst = 1'b0;
        forever begin
            @(negedge clk);
            #4;
            if (prev_rst && !rst) begin
                chk("rst_out_valid", {31'h0, out_valid}, 0);
                chk("rst_asrc1", asrc1, 0);
                chk("rst_asrc2", asrc2, 0);
                chk("rst_funcEU", {22'h0, funcEU}, 0);
                chk("rst_out_rd", {27'h0, out_rd}, 0);
                chk("rst_out_cls", {29'h0, out_cls}, 0);
                chk("rst_out_pc", out_pc, RstPc);
            end
            prev_rst = rst;
            if (rst) begin
                sb_q.delete();
                continue;
            end
            chk("out_valid", {31'h0, out_valid}, {31'h0, sb_q.size() > 0});
            if (out_valid && sb_q.size() > 0) begin
                f = sb_q[0];
                chk("asrc1", asrc1, f.asrc1);
                chk("asrc2", asrc2, f.asrc2);
                chk("funcEU", {22'h0, funcEU}, {22'h0, f.func});
                chk("out_rd", {27'h0, out_rd}, {27'h0, f.rd});
                chk("out_cls", {29'h0, out_cls}, {29'h0, f.cls});
                chk("out_pc", out_pc, f.pc);
            end
`ifdef ISSUE_SKID_EN
            exp_ready = !flush && sb_q.size() < 2;
`else
            exp_ready = !flush && (sb_q.size() == 0 || out_ready);
`endif
            chk("in_ready", {31'h0, in_ready}, {31'h0, exp_ready});
            if (flush) begin
                sb_q.delete();
                continue;
            end
            if (out_valid && out_ready && sb_q.size() > 0) void'(sb_q.pop_front());
            if (in_valid && in_ready)
                sb_q.push_back(use_dir ? dir_exp : ref_issue(in_inst, in_pc, rs1_data, rs2_data));
        end
    end

    initial begin : driver
        repeat (3) cycle(0, 0, 0, 1);
        cycle(0, 1, 0, 0);

        dir_beat(32'h002081B3, 32'h1000, '{5, 7, 10'h000, 3, 0, 32'h1000});       // add x3,x1,x2
        dir_beat(32'h4030D213, 32'h1004, '{5, 3, 10'h2A0, 4, 0, 32'h1004});       // srai x4,x1,3
        dir_beat(32'h00309213, 32'h1008, '{5, 3, 10'h080, 4, 0, 32'h1008});       // slli x4,x1,3
        dir_beat(32'h0020E063, 32'h8000_0010, '{5, 7, 10'h180, 0, 3, 32'h8000_0010}); // bltu
        dir_beat(32'h000000EF, 32'h100, '{32'h100, 4, 10'h000, 1, 4, 32'h100});   // jal x1,0
        dir_beat(32'h40208333, 32'h1010, '{5, 7, 10'h020, 6, 0, 32'h1010});       // sub x6,x1,x2
        dir_beat(32'h123452B7, 32'h1014, '{0, 32'h1234_5000, 10'h000, 5, 0, 32'h1014}); // lui
        dir_beat(32'h0020A023, 32'h1018, '{5, 7, 10'h000, 0, 2, 32'h1018});       // sw x2,0(x1)
        dir_beat(32'hFFFFFFFF, 32'h101C, '{0, 0, 10'h000, 0, 7, 32'h101C});       // illegal
        cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 0);

        // Stall with upstream pushing, then release.
        repeat (3) cycle(1, 0, 0, 0);
        repeat (3) cycle(1, 1, 0, 0);
        // Flush with a held beat and a beat offered.
        cycle(1, 0, 0, 0);
        cycle(1, 0, 1, 0);
        cycle(0, 1, 0, 0);
        // Reset in the middle of a stall.
        repeat (2) cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 1);
        cycle(0, 1, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
                  $urandom_range(0, 99) < 3, $urandom_range(0, 199) == 0);
        end

        repeat (4) cycle(0, 1, 0, 0);
        @(negedge clk);
        #6;
        chk("drain_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
